alu_issue_buffer: RTL and testbench

//  Sequential front/back end for the combinational 64-bit ALU: accepts operation requests on a valid/ready port,

---
 rtl/alu_issue_buffer_pkg.sv | 44 ++++
 rtl/alu_issue_buffer_if.sv | 26 ++
 rtl/alu_issue_buffer_fifo.sv | 63 ++++++
 rtl/alu_issue_buffer.sv | 67 ++++++
 tb/tb_alu_issue_buffer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_buffer_pkg.sv
// Shared ALU definitions: widths, opcodes, result record and a reference model
// of the combinational ALU the issue buffer feeds.
package alu_pkg;

   localparam int unsigned ANCHO = 64;
   localparam int unsigned OP_W  = 3;

   typedef enum logic [OP_W-1:0] {
      ALU_OP_ADD = 3'd0,
      ALU_OP_SUB = 3'd1,
      ALU_OP_AND = 3'd2,
      ALU_OP_OR  = 3'd3,
      ALU_OP_XOR = 3'd4,
      ALU_OP_SLT = 3'd5,
      ALU_OP_SLL = 3'd6,
      ALU_OP_SRL = 3'd7
   } aluOp_e;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic             zero;
      logic [ANCHO-1:0] resultado;
   } alu_res_t;

   function automatic logic [ANCHO-1:0] aluRef(input logic [ANCHO-1:0] rn,
                                               input logic [ANCHO-1:0] rm,
                                               input logic [OP_W-1:0]  op);
      logic [ANCHO-1:0] r;
      r = '0;
      case (op)
         ALU_OP_ADD: r = rn + rm;
         ALU_OP_SUB: r = rn - rm;
         ALU_OP_AND: r = rn & rm;
         ALU_OP_OR:  r = rn | rm;
         ALU_OP_XOR: r = rn ^ rm;
         ALU_OP_SLT: r = ($signed(rn) < $signed(rm)) ? ANCHO'(1) : '0;
         ALU_OP_SLL: r = rn << rm[5:0];
         ALU_OP_SRL: r = rn >> rm[5:0];
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_issue_buffer_if.sv
// Request and result handshake bundle of the ALU issue buffer.
interface alu_issue_buffer_if;
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [ANCHO-1:0] in_datoRN;
   logic [ANCHO-1:0] in_datoRM;
   logic [OP_W-1:0]  in_aluOP;
   logic             out_valid;
   logic             out_ready;
   logic [ANCHO-1:0] out_resultado;
   logic             out_zero;
   logic [OP_W-1:0]  out_aluOP;

   modport slave (
      input  in_valid, in_datoRN, in_datoRM, in_aluOP, out_ready,
      output in_ready, out_valid, out_resultado, out_zero, out_aluOP
   );

   modport master (
      output in_valid, in_datoRN, in_datoRM, in_aluOP, out_ready,
      input  in_ready, out_valid, out_resultado, out_zero, out_aluOP
   );

endinterface

// File: rtl/alu_issue_buffer_fifo.sv
// Result FIFO: storage ring plus a head register, so the head holds the last
// popped record while empty. count covers storage and head together.
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int unsigned PROF = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  alu_res_t              pushData,
   input  logic                  popReq,
   output logic                  headValid,
   output alu_res_t              headData,
   output logic [$clog2(PROF):0] count
);
   localparam int unsigned PW = $clog2(PROF);

   alu_res_t      mem [PROF];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [PW:0]   memCount;
   logic          pop;
   logic          load;

   // Head refills from storage only with entries already written, which gives
   // the extra cycle between capture and visibility.
   always_comb begin
      pop  = popReq & headValid;
      load = (memCount != '0) && (!headValid || pop);
   end

   assign count = memCount + (PW+1)'(headValid);

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         memCount  <= '0;
         headValid <= 1'b0;
         headData  <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PW'(1);
         if (load) begin
            rdPtr     <= rdPtr + PW'(1);
            headData  <= mem[rdPtr];
            headValid <= 1'b1;
         end else if (pop) begin
            headValid <= 1'b0;
         end
         case ({push, load})
            2'b10:   memCount <= memCount + (PW+1)'(1);
            2'b01:   memCount <= memCount - (PW+1)'(1);
            default: memCount <= memCount;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_buffer.sv
// Issue buffer around the combinational ALU: registers requests onto the ALU
// inputs, captures its result a cycle later and queues it for writeback.
module alu_issue_buffer
   import alu_pkg::*;
#(
   parameter int unsigned PROF = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_issue_buffer_if.slave     bus,
   output logic [ANCHO-1:0]      alu_datoRN,
   output logic [ANCHO-1:0]      alu_datoRM,
   output logic [OP_W-1:0]       alu_aluOP,
   input  logic [ANCHO-1:0]      alu_resultado,
   input  logic                  alu_zero,
   output logic [$clog2(PROF):0] ocupacion
);
   localparam int unsigned OCUP_W = $clog2(PROF) + 1;

   logic              s1Valid;
   logic              accept;
   logic [OCUP_W-1:0] fifoCount;
   logic              headValid;
   alu_res_t          headData;
   alu_res_t          pushData;

   // Credit: the in-flight stage counts against FIFO space, so in_ready
   // depends on registered state only, never on out_ready.
   assign ocupacion    = fifoCount + OCUP_W'(s1Valid);
   assign bus.in_ready = rst_n && (ocupacion < OCUP_W'(PROF));
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_datoRN <= '0;
         alu_datoRM <= '0;
         alu_aluOP  <= '0;
         s1Valid    <= 1'b0;
      end else begin
         s1Valid <= accept;
         if (accept) begin
            alu_datoRN <= bus.in_datoRN;
            alu_datoRM <= bus.in_datoRM;
            alu_aluOP  <= bus.in_aluOP;
         end
      end
   end

   assign pushData = '{op: alu_aluOP, zero: alu_zero, resultado: alu_resultado};

   alu_res_fifo #(.PROF(PROF)) uFifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (s1Valid),
      .pushData  (pushData),
      .popReq    (bus.out_ready),
      .headValid (headValid),
      .headData  (headData),
      .count     (fifoCount)
   );

   assign bus.out_valid     = headValid;
   assign bus.out_resultado = headData.resultado;
   assign bus.out_zero      = headData.zero;
   assign bus.out_aluOP     = headData.op;

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Bench for alu_issue_buffer with a behavioural ALU; a queue model is checked
// every cycle, directed scenarios pin literal results.
module tb_alu_issue_buffer;
   import alu_pkg::*;

   localparam int unsigned PROF = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] aluRN, aluRM, aluRes;
   logic [2:0]  aluOP;
   logic        aluZero;
   logic [2:0]  ocup;

   int checks = 0;
   int failures = 0;

   alu_issue_buffer_if bus ();

   alu_issue_buffer #(.PROF(PROF)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .alu_datoRN    (aluRN),
      .alu_datoRM    (aluRM),
      .alu_aluOP     (aluOP),
      .alu_resultado (aluRes),
      .alu_zero      (aluZero),
      .ocupacion     (ocup)
   );

   always_comb begin
      aluRes  = aluRef(aluRN, aluRM, aluOP);
      aluZero = (aluRes == '0);
   end

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (checked on every falling edge) -------------
   typedef struct { alu_res_t r; int accEdge; } ent_t;
   ent_t        q[$];
   int          edgeNum = 0;
   alu_res_t    lastOut = '0;
   logic [63:0] mRN = '0, mRM = '0;
   logic [2:0]  mOP = '0;

   always @(negedge clk) begin
      bit       vis, accN, popN;
      alu_res_t expOut, nr;
      if (!rst_n) begin
         q.delete();
         lastOut = '0;
         mRN = '0; mRM = '0; mOP = '0;
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_ocupacion", ocup, 0);
         chk("rst_out_resultado", bus.out_resultado, 0);
         chk("rst_alu_datoRN", aluRN, 0);
      end else begin
         // A result becomes visible two edges after its acceptance, in order.
         vis    = (q.size() > 0) && (q[0].accEdge + 2 <= edgeNum);
         expOut = vis ? q[0].r : lastOut;
         chk("m_out_valid", bus.out_valid, vis);
         chk("m_out_resultado", bus.out_resultado, expOut.resultado);
         chk("m_out_zero", bus.out_zero, expOut.zero);
         chk("m_out_aluOP", bus.out_aluOP, expOut.op);
         chk("m_ocupacion", ocup, q.size());
         chk("m_in_ready", bus.in_ready, q.size() < PROF);
         chk("m_alu_datoRN", aluRN, mRN);
         chk("m_alu_datoRM", aluRM, mRM);
         chk("m_alu_aluOP", aluOP, mOP);
         accN = bus.in_valid && (q.size() < PROF);
         popN = vis && bus.out_ready;
         edgeNum++;
         if (popN) begin
            lastOut = q[0].r;
            void'(q.pop_front());
         end
         if (accN) begin
            nr.resultado = aluRef(bus.in_datoRN, bus.in_datoRM, bus.in_aluOP);
            nr.zero      = (nr.resultado == '0);
            nr.op        = bus.in_aluOP;
            q.push_back('{r: nr, accEdge: edgeNum});
            mRN = bus.in_datoRN; mRM = bus.in_datoRM; mOP = bus.in_aluOP;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [63:0] reqRN[$], reqRM[$];
   logic [2:0]  reqOP[$];
   int          reqIdx;
   logic [63:0] gotRes[$];
   logic        gotZero[$];
   logic [2:0]  gotOp[$];
   int          gotCyc[$];
   int          cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic newTest();
      reqRN.delete(); reqRM.delete(); reqOP.delete();
      gotRes.delete(); gotZero.delete(); gotOp.delete(); gotCyc.delete();
      reqIdx = 0;
   endtask

   task automatic addReq(input logic [63:0] rn, input logic [63:0] rm, input logic [2:0] op);
      reqRN.push_back(rn); reqRM.push_back(rm); reqOP.push_back(op);
   endtask

   // readyMode: 0 hold out_ready low, 1 high, 2 random
   task automatic stream(input int maxCyc, input int readyMode, input int want);
      bit acc;
      for (int c = 0; c < maxCyc && gotRes.size() < want; c++) begin
         if (reqIdx < reqRN.size()) begin
            bus.in_valid  = 1'b1;
            bus.in_datoRN = reqRN[reqIdx];
            bus.in_datoRM = reqRM[reqIdx];
            bus.in_aluOP  = reqOP[reqIdx];
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);
         #0;
         acc = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            gotRes.push_back(bus.out_resultado);
            gotZero.push_back(bus.out_zero);
            gotOp.push_back(bus.out_aluOP);
            gotCyc.push_back(cyc);
         end
         tick();
         if (acc) reqIdx++;
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      logic [63:0] exp8 [8];
      exp8 = '{64'd13, 64'd7, 64'd2, 64'd11, 64'd9, 64'd0, 64'd80, 64'd1};
      bus.in_valid = 1'b0; bus.in_datoRN = '0; bus.in_datoRM = '0;
      bus.in_aluOP = '0; bus.out_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // 1: single SUB, latency two edges
      bus.in_valid = 1'b1; bus.in_datoRN = 64'd10; bus.in_datoRM = 64'd3; bus.in_aluOP = ALU_OP_SUB;
      tick();
      bus.in_valid = 1'b0;
      chk("t1_valid_after_N", bus.out_valid, 0);
      tick();
      chk("t1_valid_after_N1", bus.out_valid, 0);
      tick();
      chk("t1_valid_after_N2", bus.out_valid, 1);
      chk("t1_resultado", bus.out_resultado, 7);
      chk("t1_zero", bus.out_zero, 0);
      chk("t1_op", bus.out_aluOP, ALU_OP_SUB);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;

      // 2: zero result, then all eight opcodes back-to-back
      newTest();
      addReq(64'd5, 64'd5, ALU_OP_SUB);
      for (int i = 0; i < 8; i++) addReq(64'd10, 64'd3, 3'(i));
      stream(60, 1, 9);
      chk("t2_count", gotRes.size(), 9);
      if (gotRes.size() == 9) begin
         chk("t2_sub0_res", gotRes[0], 0);
         chk("t2_sub0_zero", gotZero[0], 1);
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_res%0d", i), gotRes[i+1], exp8[i]);
            chk($sformatf("t2_op%0d", i), gotOp[i+1], i);
         end
         chk("t2_slt_zero", gotZero[6], 1);
         chk("t2_throughput", gotCyc[8] - gotCyc[1], 7);
      end

      // 3: out_ready low fills to four credits, then drain
      newTest();
      for (int i = 0; i < 6; i++) addReq(64'(i + 1), 64'd1, ALU_OP_ADD);
      stream(6, 0, 99);
      chk("t3_accepted", reqIdx, 4);
      chk("t3_in_ready", bus.in_ready, 0);
      chk("t3_ocupacion", ocup, 4);
      stream(60, 1, 6);
      chk("t3_count", gotRes.size(), 6);
      for (int i = 0; i < 6 && i < gotRes.size(); i++)
         chk($sformatf("t3_res%0d", i), gotRes[i], 64'(i + 2));

      // 4: sustained traffic with random out_ready, pointers wrap several times
      newTest();
      for (int i = 0; i < 24; i++) addReq(64'(100 + i), 64'(i), 3'(i % 8));
      stream(400, 2, 24);
      chk("t4_count", gotRes.size(), 24);
      for (int i = 0; i < 24 && i < gotRes.size(); i++)
         chk($sformatf("t4_res%0d", i), gotRes[i], aluRef(64'(100 + i), 64'(i), 3'(i % 8)));

      // 5: reset with three queued entries and one in flight
      newTest();
      for (int i = 0; i < 4; i++) addReq(64'(50 + i), 64'd0, ALU_OP_OR);
      stream(4, 0, 99);
      chk("t5_ocup_before", ocup, 4);
      rst_n = 1'b0;
      #1;
      chk("t5_valid_in_reset", bus.out_valid, 0);
      chk("t5_ocup_in_reset", ocup, 0);
      chk("t5_ready_in_reset", bus.in_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_no_stale", bus.out_valid, 0);
      end

      // 6: idle holds ALU inputs; popping an empty FIFO is ignored
      newTest();
      addReq(64'd7, 64'd2, ALU_OP_XOR);
      stream(20, 1, 1);
      chk("t6_count", gotRes.size(), 1);
      bus.out_ready = 1'b1;
      repeat (10) tick();
      chk("t6_aluRN", aluRN, 7);
      chk("t6_aluRM", aluRM, 2);
      chk("t6_aluOP", aluOP, ALU_OP_XOR);
      chk("t6_ocup", ocup, 0);
      chk("t6_held_res", bus.out_resultado, 5);
      chk("t6_valid", bus.out_valid, 0);
      bus.out_ready = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
